// File: rtl/palindrome_pkg.sv
// Shared types and helpers for the palindrome engine.
// State encoding plus a width-generic bit reversal.
package palindrome_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        FINISH
    } state_t;

    localparam int MAX_WIDTH = 256;

    // Reverse the low w bits of v; w must not exceed MAX_WIDTH.
    function automatic logic [MAX_WIDTH-1:0] bitrev(
        input logic [MAX_WIDTH-1:0] v,
        input int unsigned          w
    );
        logic [MAX_WIDTH-1:0] r;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            r[i] = v[MAX_WIDTH-1-i];
        end
        return r >> (MAX_WIDTH - w);
    endfunction

endpackage

// File: rtl/palindrome_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Contents are deliberately not reset.
module regfile
    import palindrome_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_a_i,
    input  logic [AW-1:0]    raddr_b_i,
    output logic [WIDTH-1:0] rdata_a_o,
    output logic [WIDTH-1:0] rdata_b_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = mem_q[raddr_a_i];
    assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/palindrome_engine.sv
// Palindrome checker scanning r[base..ending] from both ends inward,
// in word mode or whole-bit-string mirror mode.
module palindrome_engine
    import palindrome_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             go,
    input  logic             mode,
    input  logic [AW-1:0]    base,
    input  logic [AW-1:0]    ending,
    output logic             busy,
    output logic             done,
    output logic             palindrome,
    output logic [AW-1:0]    mismatch_addr,
    output logic             bad_range
);

    state_t          state_q, state_d;
    logic [AW-1:0]   front_q, front_d;
    logic [AW-1:0]   back_q,  back_d;
    logic            mode_q,  mode_d;
    logic            mid_q,   mid_d;
    logic            pal_q,   pal_d;
    logic            bad_q,   bad_d;
    logic [AW-1:0]   mm_q,    mm_d;

    logic [WIDTH-1:0] rd_a, rd_b, rev_b;
    logic             we, term, mismatch;

    assign we = wr_en && (state_q == IDLE);

    regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rf (
        .clk_i     (clock),
        .we_i      (we),
        .waddr_i   (wr_addr),
        .wdata_i   (wr_data),
        .raddr_a_i (front_q),
        .raddr_b_i (back_q),
        .rdata_a_o (rd_a),
        .rdata_b_o (rd_b)
    );

    assign rev_b = WIDTH'(bitrev(MAX_WIDTH'(rd_b), WIDTH));

    // mid_q marks a checked middle word so the pointers never wrap.
    assign term     = mid_q || (mode_q ? (front_q > back_q)
                                       : (front_q >= back_q));
    assign mismatch = mode_q ? (rd_a != rev_b) : (rd_a != rd_b);

    always_comb begin
        state_d = state_q;
        front_d = front_q;
        back_d  = back_q;
        mode_d  = mode_q;
        mid_d   = mid_q;
        pal_d   = pal_q;
        bad_d   = bad_q;
        mm_d    = mm_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    pal_d = 1'b0;
                    mm_d  = '0;
                    mid_d = 1'b0;
                    if (base <= ending) begin
                        front_d = base;
                        back_d  = ending;
                        mode_d  = mode;
                        bad_d   = 1'b0;
                        state_d = COMPARE;
                    end else begin
                        bad_d   = 1'b1;
                        state_d = FINISH;
                    end
                end
            end
            COMPARE: begin
                if (term) begin
                    pal_d   = 1'b1;
                    state_d = FINISH;
                end else if (mismatch) begin
                    mm_d    = front_q;
                    state_d = FINISH;
                end else if (mode_q && (front_q == back_q)) begin
                    mid_d = 1'b1;
                end else begin
                    front_d = front_q + AW'(1);
                    back_d  = back_q - AW'(1);
                end
            end
            FINISH: begin
                if (!go) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            front_q <= '0;
            back_q  <= '0;
            mode_q  <= 1'b0;
            mid_q   <= 1'b0;
            pal_q   <= 1'b0;
            bad_q   <= 1'b0;
            mm_q    <= '0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            back_q  <= back_d;
            mode_q  <= mode_d;
            mid_q   <= mid_d;
            pal_q   <= pal_d;
            bad_q   <= bad_d;
            mm_q    <= mm_d;
        end
    end

    assign busy          = (state_q == COMPARE);
    assign done          = (state_q == FINISH);
    assign palindrome    = pal_q;
    assign mismatch_addr = mm_q;
    assign bad_range     = bad_q;

endmodule
